mdiv_host_seq: RTL and testbench

Host-side sequencer for the modular inversion/division core (MINV_MDIV). It accepts 256-bit operands a, b, p and a mode bit in parallel and serialises them into 16-bit words over the core's load protocol. It then pulses the core's start, waits for ready, drives the output-read strobes and reassembles the two 256-bit results. It is the bus-facing counterpart of the core's word-serial port and replaces testbench-driven loading in the integrated design.

---
 rtl/mdiv_host_seq.sv | 190 +++++++++++++++++++
 tb/tb_mdiv_host_seq.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/mdiv_host_seq.sv
// rtl/mdiv_host_seq.sv - host sequencer: serialises a/p/b into the MINV_MDIV core and reassembles x1/x2
module mdiv_host_seq #(
  parameter int TIMEOUT = 4095,
  parameter int RD_GAP  = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         mode,
  input  logic [255:0] a,
  input  logic [255:0] b,
  input  logic [255:0] p,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic         flag,
  output logic [255:0] x1,
  output logic [255:0] x2,
  output logic [15:0]  datain,
  output logic         minv_mdiv,
  output logic         loada,
  output logic         loadp,
  output logic         loadb,
  output logic         minv_mdiv_en,
  output logic         outx1,
  output logic         outx2,
  input  logic [15:0]  regx1out,
  input  logic [15:0]  regx2out,
  input  logic         minv_mdiv_rdy,
  input  logic         minv_mdiv_flag
);

  localparam logic [11:0] LP_TO       = 12'(TIMEOUT);
  localparam logic [2:0]  LP_GAP      = 3'(RD_GAP);
  localparam logic [2:0]  LP_GAP_LAST = 3'(RD_GAP - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD_A, S_LOAD_P, S_LOAD_B, S_KICK,
    S_WAIT, S_GAP, S_READ, S_DRAIN, S_FIN
  } state_t;

  state_t         r_state;
  logic [751:0]   r_sh;
  logic [3:0]     r_cnt;
  logic [11:0]    r_wcnt;
  logic [2:0]     r_gcnt;
  logic           r_cap_en;
  logic [3:0]     r_cap_idx;
  logic           r_busy, r_done, r_err, r_flag, r_mode;
  logic           r_loada, r_loadp, r_loadb, r_en, r_outx;
  logic [15:0]    r_datain;
  logic [255:0]   r_x1, r_x2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_sh      <= '0;
      r_cnt     <= '0;
      r_wcnt    <= '0;
      r_gcnt    <= '0;
      r_cap_en  <= 1'b0;
      r_cap_idx <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_flag    <= 1'b0;
      r_mode    <= 1'b0;
      r_loada   <= 1'b0;
      r_loadp   <= 1'b0;
      r_loadb   <= 1'b0;
      r_en      <= 1'b0;
      r_outx    <= 1'b0;
      r_datain  <= '0;
      r_x1      <= '0;
      r_x2      <= '0;
    end else begin
      r_done    <= 1'b0;
      r_en      <= 1'b0;
      // the core answers one cycle after each strobe, so capture trails the strobe by one edge
      r_cap_en  <= r_outx;
      r_cap_idx <= r_cnt;
      if (r_cap_en) begin
        r_x1[{r_cap_idx, 4'b0000} +: 16] <= regx1out;
        r_x2[{r_cap_idx, 4'b0000} +: 16] <= regx2out;
      end
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state  <= S_LOAD_A;
            r_busy   <= 1'b1;
            r_mode   <= mode;
            r_err    <= 1'b0;
            r_flag   <= 1'b0;
            r_loada  <= 1'b1;
            r_datain <= a[15:0];
            r_sh     <= {b, p, a[255:16]};
            r_cnt    <= '0;
          end
        end
        S_LOAD_A, S_LOAD_P, S_LOAD_B: begin
          r_cnt    <= r_cnt + 4'd1;
          r_datain <= r_sh[15:0];
          r_sh     <= {16'h0000, r_sh[751:16]};
          if (r_cnt == 4'd15) begin
            if (r_state == S_LOAD_A) begin
              r_loada <= 1'b0;
              r_loadp <= 1'b1;
              r_state <= S_LOAD_P;
            end else if (r_state == S_LOAD_P) begin
              r_loadp <= 1'b0;
              r_loadb <= 1'b1;
              r_state <= S_LOAD_B;
            end else begin
              r_loadb  <= 1'b0;
              r_en     <= 1'b1;
              r_datain <= '0;
              r_state  <= S_KICK;
            end
          end
        end
        S_KICK: begin
          r_wcnt  <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // rdy is checked before the timeout so a coincident rdy still succeeds
          if (minv_mdiv_rdy) begin
            r_flag <= minv_mdiv_flag;
            r_cnt  <= '0;
            r_gcnt <= '0;
            if (LP_GAP == 3'd0) begin
              r_outx  <= 1'b1;
              r_state <= S_READ;
            end else begin
              r_state <= S_GAP;
            end
          end else if (r_wcnt == LP_TO) begin
            r_err   <= 1'b1;
            r_x1    <= '0;
            r_x2    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_FIN;
          end else begin
            r_wcnt <= r_wcnt + 12'd1;
          end
        end
        S_GAP: begin
          if (r_gcnt == LP_GAP_LAST) begin
            r_outx  <= 1'b1;
            r_cnt   <= '0;
            r_state <= S_READ;
          end else begin
            r_gcnt <= r_gcnt + 3'd1;
          end
        end
        S_READ: begin
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == 4'd15) begin
            r_outx  <= 1'b0;
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_FIN;
        end
        S_FIN:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy         = r_busy;
  assign done         = r_done;
  assign err          = r_err;
  assign flag         = r_flag;
  assign x1           = r_x1;
  assign x2           = r_x2;
  assign datain       = r_datain;
  assign minv_mdiv    = r_mode;
  assign loada        = r_loada;
  assign loadp        = r_loadp;
  assign loadb        = r_loadb;
  assign minv_mdiv_en = r_en;
  assign outx1        = r_outx;
  assign outx2        = r_outx;

endmodule

// File: tb/tb_mdiv_host_seq.sv
// tb/tb_mdiv_host_seq.sv - self-checking bench for mdiv_host_seq
module tb_mdiv_host_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         start[2], mode[2], rdy[2], flg[2];
  logic [255:0] a[2], b[2], p[2], res1[2], res2[2];
  logic         busy[2], done[2], err[2], flag[2], mm[2];
  logic         loada[2], loadp[2], loadb[2], en[2], outx1[2], outx2[2];
  logic [255:0] x1[2], x2[2];
  logic [15:0]  datain[2];
  int total = 0;
  int bad   = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int LP_TO  = (g == 0) ? 400 : 20;
    localparam int LP_GAP = (g == 0) ? 2 : 0;
    logic [15:0] rx1, rx2;
    int idx;

    mdiv_host_seq #(.TIMEOUT(LP_TO), .RD_GAP(LP_GAP)) u_dut (
      .clk(clk), .rst(rst), .start(start[g]), .mode(mode[g]),
      .a(a[g]), .b(b[g]), .p(p[g]),
      .busy(busy[g]), .done(done[g]), .err(err[g]), .flag(flag[g]),
      .x1(x1[g]), .x2(x2[g]), .datain(datain[g]), .minv_mdiv(mm[g]),
      .loada(loada[g]), .loadp(loadp[g]), .loadb(loadb[g]),
      .minv_mdiv_en(en[g]), .outx1(outx1[g]), .outx2(outx2[g]),
      .regx1out(rx1), .regx2out(rx2),
      .minv_mdiv_rdy(rdy[g]), .minv_mdiv_flag(flg[g])
    );

    // core read port: word i appears the cycle after the i-th strobe
    always @(posedge clk) begin
      if (!rst || en[g]) begin
        idx <= 0;
      end else if (outx1[g]) begin
        rx1 <= res1[g][16*idx +: 16];
        rx2 <= res2[g][16*idx +: 16];
        idx <= idx + 1;
      end
    end
  end

  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  task automatic chk_zero(input int g, input string tag);
    logic [538:0] got;
    got = {busy[g], done[g], err[g], flag[g], mm[g], loada[g], loadp[g], loadb[g],
           en[g], outx1[g], outx2[g], datain[g], x1[g], x2[g]};
    total++;
    assert (got === '0) else begin
      bad++;
      $error("FAIL %s g=%0d got=%h exp=0", tag, g, got);
    end
  endtask

  // rcyc: first cycle rdy is high (-1 = never); st1/st2: stray start cycles; spur: rdy pulse in LOAD_B
  task automatic run_op(input int g, input logic md, input logic [255:0] av, input logic [255:0] bv,
                        input logic [255:0] pv, input logic [255:0] r1, input logic [255:0] r2,
                        input logic fv, input int rcyc, input int st1, input int st2, input bit spur);
    int tmo, gap, dcyc;
    bit to, la, lp, lb, ox;
    logic [8:0] ectl, gctl;
    logic [15:0] w;
    tmo  = (g == 0) ? 400 : 20;
    gap  = (g == 0) ? 2 : 0;
    to   = (rcyc < 0) || (rcyc > 50 + tmo);
    dcyc = to ? 51 + tmo : rcyc + 18 + gap;
    @(negedge clk);
    a[g] = av; b[g] = bv; p[g] = pv; mode[g] = md;
    res1[g] = r1; res2[g] = r2;
    rdy[g] = 1'b0; flg[g] = ~fv; start[g] = 1'b1;
    for (int c = 1; c <= dcyc + 1; c++) begin
      @(negedge clk);
      start[g] = (c == st1) || (c == st2);
      if (c == 1) begin
        a[g] = ~av; b[g] = ~bv; p[g] = ~pv; mode[g] = ~md;
      end
      la = (c >= 1) && (c <= 16);
      lp = (c >= 17) && (c <= 32);
      lb = (c >= 33) && (c <= 48);
      ox = !to && (c >= rcyc + 1 + gap) && (c <= rcyc + 16 + gap);
      ectl = {c < dcyc, c == dcyc, la, lp, lb, c == 49, ox, ox, md};
      gctl = {busy[g], done[g], loada[g], loadp[g], loadb[g], en[g], outx1[g], outx2[g], mm[g]};
      total++;
      assert (gctl === ectl) else begin
        bad++;
        $error("FAIL ctl g=%0d cyc=%0d got=%b exp=%b", g, c, gctl, ectl);
      end
      if (la || lp || lb) begin
        w = la ? av[16*(c-1) +: 16] : lp ? pv[16*(c-17) +: 16] : bv[16*(c-33) +: 16];
        total++;
        assert (datain[g] === w) else begin
          bad++;
          $error("FAIL datain g=%0d cyc=%0d got=%h exp=%h", g, c, datain[g], w);
        end
      end
      if (c >= dcyc) begin
        total++;
        assert ({err[g], x1[g], x2[g]} === {to, to ? 256'd0 : r1, to ? 256'd0 : r2}) else begin
          bad++;
          $error("FAIL result g=%0d cyc=%0d got=%b/%h/%h exp=%b/%h/%h", g, c, err[g], x1[g], x2[g],
                 to, to ? 256'd0 : r1, to ? 256'd0 : r2);
        end
        if (!to) begin
          total++;
          assert (flag[g] === fv) else begin
            bad++;
            $error("FAIL flag g=%0d cyc=%0d got=%b exp=%b", g, c, flag[g], fv);
          end
        end
      end
      rdy[g] = (spur && c >= 35 && c <= 40) || (rcyc >= 0 && c >= rcyc && c < dcyc);
      flg[g] = (c == rcyc) ? fv : ~fv;
    end
    rdy[g] = 1'b0;
  endtask

  localparam logic [255:0] SM2_P =
    256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFF;

  initial begin
    int g, rc;
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start[i] = 0; mode[i] = 0; rdy[i] = 0; flg[i] = 0;
      a[i] = '0; b[i] = '0; p[i] = '0; res1[i] = '0; res2[i] = '0;
    end
    repeat (3) @(negedge clk);
    chk_zero(0, "reset0");
    chk_zero(1, "reset1");
    rst = 1'b1;

    run_op(0, 1'b1, 256'd5, 256'd0, 256'd11, 256'd9, rnd256(), 1'b1, 60, 0, 0, 1'b0);
    run_op(0, 1'b0, rnd256(), rnd256(), SM2_P, rnd256(), rnd256(), 1'b0, 350, 0, 0, 1'b0);
    run_op(1, 1'b1, rnd256(), rnd256(), rnd256(), rnd256(), rnd256(), 1'b1, -1, 0, 0, 1'b0);
    run_op(0, 1'b1, rnd256(), rnd256(), rnd256(), rnd256(), rnd256(), 1'b1, 100, 20, 60, 1'b1);

    @(negedge clk);
    a[0] = rnd256(); b[0] = rnd256(); p[0] = rnd256(); mode[0] = 1'b1; start[0] = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      start[0] = 1'b0;
    end
    rst = 1'b0;
    #1;
    chk_zero(0, "midrst");
    @(negedge clk);
    rst = 1'b1;
    run_op(0, 1'b0, rnd256(), rnd256(), rnd256(), rnd256(), rnd256(), 1'b1, 75, 0, 0, 1'b0);

    run_op(1, 1'b0, rnd256(), rnd256(), rnd256(), rnd256(), rnd256(), 1'b1, 50, 0, 0, 1'b0);
    run_op(1, 1'b1, rnd256(), rnd256(), rnd256(), rnd256(), rnd256(), 1'b0, 70, 0, 0, 1'b0);
    run_op(1, 1'b1, rnd256(), rnd256(), rnd256(), rnd256(), rnd256(), 1'b1, 71, 0, 0, 1'b0);

    for (int k = 0; k < 4; k++) begin
      g  = int'($urandom_range(0, 1));
      rc = int'($urandom_range(50, 120));
      run_op(g, 1'($urandom), rnd256(), rnd256(), rnd256(), rnd256(), rnd256(), 1'($urandom),
             rc, 0, 0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
